// File: rtl/render_pkg.sv
// Shared types for the render scheduler: FSM states, particle layout and a popcount helper.
package render_pkg;

    localparam int COORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] z;
        logic [COORD_WIDTH-1:0] y;
        logic [COORD_WIDTH-1:0] x;
    } particle_t;

    // Instance masks are at most 16 wide, so callers zero-extend into this helper.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/render_scheduler_rr_picker.sv
// Combinational round-robin select: first requester at or after ptr_i, wrapping modulo N.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// Frame-level round-robin dispatcher feeding NUM_INST render instances from one particle stream.
// Optional drain watchdog is enabled by defining RENDER_SCHED_WATCHDOG_EN.
module render_scheduler #(
    parameter int NUM_INST    = 4,
    parameter int COORD_WIDTH = render_pkg::COORD_WIDTH,
    parameter int CNT_WIDTH   = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         frame_start_in,
    input  logic [CNT_WIDTH-1:0]         particle_count_in,
    input  logic                         p_valid_in,
    input  logic [3*COORD_WIDTH-1:0]     p_data_in,
    output logic                         p_ready_out,
    input  logic [NUM_INST-1:0]          inst_ready_in,
    input  logic [NUM_INST-1:0]          inst_retire_in,
    output logic [NUM_INST-1:0]          inst_valid_out,
    output logic [3*COORD_WIDTH-1:0]     inst_data_out,
    output logic                         busy_out,
    output logic                         frame_done_out,
    output logic [$clog2(NUM_INST+1)-1:0] in_flight_out,
    output logic                         timeout_out
);

    import render_pkg::*;

    localparam int PW  = $clog2(NUM_INST);
    localparam int IFW = $clog2(NUM_INST + 1);
    localparam int DW  = 3 * COORD_WIDTH;

    sched_state_t         state_q;
    logic [CNT_WIDTH-1:0] target_q, dispatched_q, dispatched_d;
    logic [NUM_INST-1:0]  claimed_q, claimed_d, eligible, grant, valid_q;
    logic [PW-1:0]        rr_q, rr_d, grant_idx;
    logic [DW-1:0]        data_q;
    logic [IFW-1:0]       in_flight_q;
    logic                 done_q, grant_any, p_ready, accept;

    assign eligible = inst_ready_in & ~claimed_q;

    rr_picker #(.N(NUM_INST), .PW(PW)) u_picker (
        .req_i   (eligible),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // A retire and a grant never target the same instance, so clear-then-set is safe.
    always_comb begin
        p_ready      = (state_q == DISPATCH) && (dispatched_q < target_q) && grant_any;
        accept       = p_valid_in && p_ready;
        claimed_d    = claimed_q & ~inst_retire_in;
        dispatched_d = dispatched_q;
        rr_d         = rr_q;
        if (accept) begin
            claimed_d    = claimed_d | grant;
            dispatched_d = dispatched_q + CNT_WIDTH'(1);
            rr_d         = (grant_idx == PW'(NUM_INST - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

`ifdef RENDER_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q;
    logic          timeout_q;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            target_q     <= '0;
            dispatched_q <= '0;
            claimed_q    <= '0;
            rr_q         <= '0;
            valid_q      <= '0;
            data_q       <= '0;
            in_flight_q  <= '0;
            done_q       <= 1'b0;
`ifdef RENDER_SCHED_WATCHDOG_EN
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            valid_q     <= '0;
            done_q      <= 1'b0;
            claimed_q   <= claimed_d;
            in_flight_q <= IFW'(popcount16(16'(claimed_d)));
            if (accept) begin
                valid_q      <= grant;
                data_q       <= p_data_in;
                rr_q         <= rr_d;
                dispatched_q <= dispatched_d;
            end
            case (state_q)
                IDLE: begin
                    if (frame_start_in) begin
                        target_q     <= particle_count_in;
                        dispatched_q <= '0;
                        state_q      <= (particle_count_in == '0) ? DONE : DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (accept && (dispatched_d == target_q)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (claimed_d == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef RENDER_SCHED_WATCHDOG_EN
            // Stalls with no accept or retire eventually force the frame closed.
            if ((state_q == DISPATCH) || (state_q == DRAIN)) begin
                if (accept || (inst_retire_in != '0)) begin
                    wdog_q <= '0;
                end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                    wdog_q      <= '0;
                    claimed_q   <= '0;
                    in_flight_q <= '0;
                    timeout_q   <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    wdog_q <= wdog_q + WW'(1);
                end
            end else begin
                wdog_q <= '0;
            end
`endif
        end
    end

    assign p_ready_out    = p_ready;
    assign inst_valid_out = valid_q;
    assign inst_data_out  = data_q;
    assign busy_out       = (state_q != IDLE);
    assign frame_done_out = done_q;
    assign in_flight_out  = in_flight_q;
`ifdef RENDER_SCHED_WATCHDOG_EN
    assign timeout_out    = timeout_q;
`else
    assign timeout_out    = 1'b0;
`endif

endmodule

// File: tb/tb_render_scheduler.sv
// Directed testbench for render_scheduler; the watchdog scenario builds only with RENDER_SCHED_WATCHDOG_EN.
module tb_render_scheduler;

    import render_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        frame_start_in;
    logic [15:0] particle_count_in;
    logic        p_valid_in;
    logic [47:0] p_data_in;
    logic        p_ready_out;
    logic [3:0]  inst_ready_in;
    logic [3:0]  inst_retire_in;
    logic [3:0]  inst_valid_out;
    logic [47:0] inst_data_out;
    logic        busy_out;
    logic        frame_done_out;
    logic [2:0]  in_flight_out;
    logic        timeout_out;

    int vectors = 0;
    int miscompares = 0;

    render_scheduler #(
        .NUM_INST(4), .COORD_WIDTH(16), .CNT_WIDTH(16), .WDOG_CYCLES(16)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .particle_count_in(particle_count_in), .p_valid_in(p_valid_in),
        .p_data_in(p_data_in), .p_ready_out(p_ready_out),
        .inst_ready_in(inst_ready_in), .inst_retire_in(inst_retire_in),
        .inst_valid_out(inst_valid_out), .inst_data_out(inst_data_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out),
        .in_flight_out(in_flight_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [47:0] part(input int k);
        particle_t p;
        p.x = 16'h1000 + 16'(k);
        p.y = 16'h2000 + 16'(k);
        p.z = 16'h3000 + 16'(k);
        return p;
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] count);
        frame_start_in    = 1'b1;
        particle_count_in = count;
        tick();
        frame_start_in    = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        frame_start_in = 1'b1; particle_count_in = 16'd5;
        p_valid_in = 1'b1; p_data_in = 48'hDEAD_BEEF_CAFE;
        inst_ready_in = 4'hF; inst_retire_in = 4'h0;
        repeat (3) tick();
        vectors++;
        if ({inst_valid_out, inst_data_out, busy_out, frame_done_out, in_flight_out, timeout_out, p_ready_out} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h busy=%b done=%b inflight=%0d timeout=%b ready=%b, expected all zero",
                     inst_valid_out, inst_data_out, busy_out, frame_done_out, in_flight_out, timeout_out, p_ready_out);
        end
        frame_start_in = 1'b0; p_valid_in = 1'b0;
        rst_in = 1'b1;
        tick();
        vectors++;
        if (busy_out !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %b expected 0", busy_out); end
        start_frame(16'd0);
        vectors++;
        if (frame_done_out !== 1'b0 || busy_out !== 1'b1) begin
            miscompares++; $display("[TB] FAIL zero_frame_c1: got done=%b busy=%b expected done=0 busy=1", frame_done_out, busy_out);
        end
        tick();
        vectors++;
        if (frame_done_out !== 1'b1 || inst_valid_out !== 4'h0) begin
            miscompares++; $display("[TB] FAIL zero_frame_c2: got done=%b valid=%b expected done=1 valid=0000", frame_done_out, inst_valid_out);
        end
        tick();
        vectors++;
        if (frame_done_out !== 1'b0 || busy_out !== 1'b0) begin
            miscompares++; $display("[TB] FAIL zero_frame_c3: got done=%b busy=%b expected 0 0", frame_done_out, busy_out);
        end
    endtask

    task automatic test_round_robin;
        int k = 0, retired = 0, outstanding = 0, doneCount = 0;
        int cd[4] = '{0, 0, 0, 0};
        logic [3:0] retPrev = 4'h0, newRet, expGrant;
        inst_ready_in = 4'hF; p_valid_in = 1'b1; p_data_in = part(0);
        start_frame(16'd8);
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (inst_valid_out != 4'h0) outstanding++;
            outstanding -= $countones(retPrev);
            retired     += $countones(retPrev);
            if (inst_valid_out != 4'h0) begin
                expGrant = 4'b0001 << (k % 4);
                vectors++;
                if (inst_valid_out !== expGrant || inst_data_out !== part(k)) begin
                    miscompares++;
                    $display("[TB] FAIL rr_dispatch%0d: got valid=%b data=%h expected valid=%b data=%h",
                             k, inst_valid_out, inst_data_out, expGrant, part(k));
                end
                k++;
                p_data_in = part(k);
            end
            vectors++;
            if (in_flight_out !== 3'(outstanding)) begin
                miscompares++; $display("[TB] FAIL rr_inflight: got %0d expected %0d", in_flight_out, outstanding);
            end
            if (frame_done_out === 1'b1) begin
                doneCount++;
                vectors++;
                if (retired !== 8) begin
                    miscompares++; $display("[TB] FAIL rr_done_early: got %0d retires expected 8", retired);
                end
            end
            newRet = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) newRet[i] = 1'b1;
                end
                if (inst_valid_out[i]) cd[i] = 2;
            end
            inst_retire_in = newRet;
            retPrev = newRet;
        end
        vectors++;
        if (k !== 8) begin miscompares++; $display("[TB] FAIL rr_count: got %0d dispatches expected 8", k); end
        vectors++;
        if (doneCount !== 1) begin miscompares++; $display("[TB] FAIL rr_done_count: got %0d expected 1", doneCount); end
        inst_retire_in = 4'h0; p_valid_in = 1'b0;
    endtask

    task automatic test_back_pressure;
        logic [3:0] expSeq[3] = '{4'b0010, 4'b0100, 4'b1000};
        int j = 0, doneCount = 0;
        inst_ready_in = 4'hF; p_valid_in = 1'b1; p_data_in = part(20);
        start_frame(16'd4);
        tick();
        vectors++;
        if (inst_valid_out !== 4'b0001) begin
            miscompares++; $display("[TB] FAIL bp_first: got %b expected 0001", inst_valid_out);
        end
        inst_ready_in = 4'h0; inst_retire_in = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if (p_ready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready: got %b expected 0", p_ready_out); end
            tick();
            inst_retire_in = 4'h0;
            vectors++;
            if (inst_valid_out !== 4'h0) begin miscompares++; $display("[TB] FAIL bp_dispatch: got %b expected 0000", inst_valid_out); end
        end
        inst_ready_in = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick();
            inst_retire_in = 4'h0;
            if (frame_done_out === 1'b1) doneCount++;
            if (inst_valid_out != 4'h0) begin
                vectors++;
                if (j > 2 || inst_valid_out !== expSeq[j > 2 ? 2 : j]) begin
                    miscompares++; $display("[TB] FAIL bp_resume%0d: got %b expected %b", j, inst_valid_out, expSeq[j > 2 ? 2 : j]);
                end
                j++;
                inst_retire_in = inst_valid_out;
            end
        end
        vectors++;
        if (j !== 3 || doneCount !== 1) begin
            miscompares++; $display("[TB] FAIL bp_total: got %0d dispatches %0d dones expected 3 and 1", j, doneCount);
        end
        p_valid_in = 1'b0;
    endtask

    task automatic test_skip_busy;
        logic [3:0] stimReady[4] = '{4'b0010, 4'b0001, 4'b1111, 4'b1111};
        logic [3:0] expGrant[4]  = '{4'b0010, 4'b0001, 4'b0100, 4'b1000};
        bit seen = 0;
        p_valid_in = 1'b1; p_data_in = part(40);
        start_frame(16'd4);
        for (int i = 0; i < 4; i++) begin
            inst_ready_in = stimReady[i];
            tick();
            vectors++;
            if (inst_valid_out !== expGrant[i]) begin
                miscompares++; $display("[TB] FAIL skip_grant%0d: got %b expected %b", i, inst_valid_out, expGrant[i]);
            end
        end
        vectors++;
        if (in_flight_out !== 3'd4) begin miscompares++; $display("[TB] FAIL skip_inflight: got %0d expected 4", in_flight_out); end
        p_valid_in = 1'b0; inst_retire_in = 4'hF;
        tick();
        inst_retire_in = 4'h0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (frame_done_out === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("[TB] FAIL skip_done: got no frame_done expected one"); end
    endtask

    task automatic test_retire_grant;
        inst_ready_in = 4'hF; p_valid_in = 1'b1; p_data_in = part(60);
        start_frame(16'd3);
        tick();
        tick();
        vectors++;
        if (inst_valid_out !== 4'b0010 || in_flight_out !== 3'd2) begin
            miscompares++; $display("[TB] FAIL rg_setup: got valid=%b inflight=%0d expected 0010 2", inst_valid_out, in_flight_out);
        end
        inst_ready_in = 4'b1000; inst_retire_in = 4'b0010;
        tick();
        vectors++;
        if (inst_valid_out !== 4'b1000 || in_flight_out !== 3'd2) begin
            miscompares++; $display("[TB] FAIL rg_same_cycle: got valid=%b inflight=%0d expected 1000 2", inst_valid_out, in_flight_out);
        end
        p_valid_in = 1'b0; inst_retire_in = 4'b0100;
        tick();
        vectors++;
        if (in_flight_out !== 3'd2) begin miscompares++; $display("[TB] FAIL rg_stray_retire: got %0d expected 2", in_flight_out); end
        inst_retire_in = 4'h0;
        start_frame(16'd5);
        vectors++;
        if (busy_out !== 1'b1 || frame_done_out !== 1'b0 || in_flight_out !== 3'd2 || inst_valid_out !== 4'h0) begin
            miscompares++; $display("[TB] FAIL rg_drain_start: got busy=%b done=%b inflight=%0d valid=%b expected 1 0 2 0000",
                                    busy_out, frame_done_out, in_flight_out, inst_valid_out);
        end
        inst_ready_in = 4'hF; inst_retire_in = 4'b1001;
        tick();
        inst_retire_in = 4'h0;
        tick();
        vectors++;
        if (frame_done_out !== 1'b1 || in_flight_out !== 3'd0) begin
            miscompares++; $display("[TB] FAIL rg_done: got done=%b inflight=%0d expected 1 0", frame_done_out, in_flight_out);
        end
        p_valid_in = 1'b1;
        tick();
        #1;
        vectors++;
        if (busy_out !== 1'b0 || p_ready_out !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rg_no_restart: got busy=%b ready=%b expected 0 0", busy_out, p_ready_out);
        end
        p_valid_in = 1'b0;
    endtask

`ifdef RENDER_SCHED_WATCHDOG_EN
    task automatic test_watchdog;
        int n = 0;
        inst_ready_in = 4'hF; p_valid_in = 1'b1; p_data_in = part(80);
        start_frame(16'd2);
        tick();
        tick();
        p_valid_in = 1'b0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (timeout_out === 1'b1) n = i;
        end
        vectors++;
        if (n !== 16 || in_flight_out !== 3'd0) begin
            miscompares++; $display("[TB] FAIL wdog_timeout: got cycle %0d inflight=%0d expected 16 0", n, in_flight_out);
        end
        tick();
        vectors++;
        if (frame_done_out !== 1'b1 || timeout_out !== 1'b1) begin
            miscompares++; $display("[TB] FAIL wdog_done: got done=%b timeout=%b expected 1 1", frame_done_out, timeout_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_skip_busy();
        test_retire_grant();
`ifdef RENDER_SCHED_WATCHDOG_EN
        test_watchdog();
`else
        vectors++;
        if (timeout_out !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_tied: got %b expected 0", timeout_out); end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
- Frame-level controller that feeds a pool of NUM_INST parallel render instances from one particle stream.
- Accepts a per-frame particle count, dispatches each particle to a free instance using round-robin, and tracks in-flight work.
- Pulses frame_done when every particle of the frame has been dispatched and retired.
- Sits between the particle buffer / FIFO and the render instances; it replaces a blind bus driver.

Parameters:
- NUM_INST, 4, number of render instances scheduled (2..16)
- COORD_WIDTH, 16, width of each of x/y/z
- CNT_WIDTH, 16, width of particle counters
- WDOG_CYCLES, 4096, drain timeout; used only with the optional feature

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- frame_start_in  input  1  pulse; starts a frame (honoured only in IDLE)
- particle_count_in  input  CNT_WIDTH  particles in the frame; sampled with frame_start_in
- p_valid_in  input  1  particle stream valid
- p_data_in  input  3*COORD_WIDTH  {z,y,x}
- p_ready_out  output  1  scheduler accepts a particle this cycle
- inst_ready_in  input  NUM_INST  per-instance ready to accept
- inst_retire_in  input  NUM_INST  per-instance 1-cycle pulse: particle finished
- inst_valid_out  output  NUM_INST  one-hot 1-cycle dispatch strobe
- inst_data_out  output  3*COORD_WIDTH  broadcast particle data, valid with inst_valid_out
- busy_out  output  1  high in every state except IDLE
- frame_done_out  output  1  1-cycle pulse at end of frame
- in_flight_out  output  $clog2(NUM_INST+1)  count of claimed instances
- timeout_out  output  1  sticky timeout flag (feature only; tied 0 otherwise)

Behaviour:
- Reset (rst_in==0 at posedge):
  - state=IDLE; claimed mask=0; counters=0; rr pointer=0.
  - All outputs 0; inst_data_out=0.
  - Reset mid-frame abandons the frame, with no frame_done.
- FSM states:
  - IDLE -> on frame_start_in: latch target=particle_count_in, dispatched=0. Go to DISPATCH, or to DONE if target==0.
  - DISPATCH: when dispatched==target after an accept, go to DRAIN.
  - DRAIN: when claimed==0, go to DONE (the same-cycle retire counts).
  - DONE: frame_done_out=1 for exactly one cycle, then IDLE.
- Eligibility: eligible[i] = inst_ready_in[i] & ~claimed[i].
- p_ready_out (combinational) = (state==DISPATCH) & (dispatched<target) & |eligible.
- Grant:
  - Pick the first eligible index at or after rr_ptr, wrapping modulo NUM_INST.
  - On p_valid_in & p_ready_out:
    - claimed[g]<=1
    - rr_ptr<=(g+1)%NUM_INST
    - dispatched+=1
    - inst_data_out<=p_data_in
    - inst_valid_out<=onehot(g)
  - Dispatch latency: 1 cycle, registered. Otherwise inst_valid_out<=0 and inst_data_out holds.
- Retire:
  - inst_retire_in[i] clears claimed[i].
  - A retire on an unclaimed instance is ignored.
  - A retire and a grant to different instances in the same cycle both take effect.
  - A retire on i and a grant to i cannot coincide, because claimed blocks the grant.
- A freed instance is eligible the cycle after its retire.
- in_flight_out = popcount(claimed), registered.
- frame_start_in outside IDLE is ignored.
- p_valid_in outside DISPATCH is not accepted and the data is not consumed.
- Counters never wrap: target ≤ 2^CNT_WIDTH−1, and dispatched stops at target.

Optional Feature:
- Macro: RENDER_SCHED_WATCHDOG_EN.
- Enabled:
  - A counter runs in DISPATCH and DRAIN; it resets on any accept or retire.
  - Reaching WDOG_CYCLES forces claimed=0, sets timeout_out (sticky until reset), and goes to DONE, which still pulses frame_done_out.
- Disabled:
  - No counter; timeout_out tied 0.
  - The FSM can wait forever.

Decomposition:
- Package render_pkg contains:
  - sched_state_t enum {IDLE, DISPATCH, DRAIN, DONE}
  - COORD_WIDTH
  - particle_t packed struct {z,y,x}
- Sub-module rr_picker (parameter N): combinational round-robin priority select; inputs req[N] and ptr, outputs grant one-hot and grant index plus any.

Test Plan:
- Reset then idle:
  - Stimulus: rst_in=0 for 3 cycles, then 1.
  - Required: all outputs 0, busy_out=0; frame_start_in with count=0 -> frame_done_out pulses 2 cycles later, no inst_valid_out.
- Round-robin order:
  - Stimulus: NUM_INST=4, all ready, count=8, p_valid_in held high, retire each instance 3 cycles after its dispatch.
  - Required: inst_valid_out sequence 0001,0010,0100,1000,0001…; frame_done_out exactly once after the 8th retire.
- Back-pressure:
  - Stimulus: inst_ready_in=0000 for 10 cycles mid-frame.
  - Required: p_ready_out=0 throughout; no dispatch; dispatched count unchanged.
- Skip busy instance:
  - Stimulus: claimed=0011 with rr_ptr=1, instances 2 and 3 ready.
  - Required: next grant is 0100, then 1000.
- Simultaneous retire/grant and ignored inputs:
  - Stimulus: retire on instance 1 and accept to instance 3 in the same cycle; a stray retire on an unclaimed instance; frame_start_in during DRAIN.
  - Required: in_flight_out unchanged; claimed unchanged by the stray retire; no restart.
- Watchdog (RENDER_SCHED_WATCHDOG_EN, WDOG_CYCLES=16):
  - Stimulus: count=2, never retire.
  - Required: timeout_out=1 and frame_done_out pulse 16 cycles after the last dispatch; claimed=0.
